// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory waits, taken branch and HLT drain.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [3:0]       IDEX_RegRd,
  input  logic [3:0]       IFID_RegRs,
  input  logic [3:0]       IFID_RegRt,
  input  logic             IFID_UsesRt,
  input  logic             branch_taken,
  input  logic             hlt_id,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             IFID_stall,
  output logic             IDEX_stall,
  output logic             EXMEM_stall,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             MEMWB_flush,
  output logic             halted,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
`endif
  output logic             mem_err
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [DW-1:0] drain_cnt_r;
  logic [WW-1:0] wd_cnt_r;
  logic          mem_err_r;

  logic luse_s;
  logic drain_load_s, drain_inc_s;
  logic pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s;
  logic ifid_flush_s, idex_flush_s, memwb_flush_s;

  assign luse_s = IDEX_MemRead && (IDEX_RegRd != 4'd0) &&
                  ((IDEX_RegRd == IFID_RegRs) || (IFID_UsesRt && (IDEX_RegRd == IFID_RegRt)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and stall/flush decode; one priority row per cycle
  always_comb begin
    state_nxt_s   = state_r;
    drain_load_s  = 1'b0;
    drain_inc_s   = 1'b0;
    pc_stall_s    = 1'b0;
    ifid_stall_s  = 1'b0;
    idex_stall_s  = 1'b0;
    exmem_stall_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    memwb_flush_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (dmem_busy) begin
          pc_stall_s    = 1'b1;
          ifid_stall_s  = 1'b1;
          idex_stall_s  = 1'b1;
          exmem_stall_s = 1'b1;
          memwb_flush_s = 1'b1;
        end else if (imem_busy) begin
          pc_stall_s   = 1'b1;
          ifid_flush_s = 1'b1;
        end else if (luse_s) begin
          pc_stall_s   = 1'b1;
          ifid_stall_s = 1'b1;
          idex_flush_s = 1'b1;
        end else if (branch_taken) begin
          ifid_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
        // HLT only leaves RUN once nothing above it is holding ID
        if (hlt_id && !dmem_busy && !imem_busy && !luse_s) begin
          state_nxt_s  = ST_DRAIN;
          drain_load_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        pc_stall_s   = 1'b1;
        ifid_flush_s = 1'b1;
        if (dmem_busy) begin
          ifid_stall_s  = 1'b1;
          idex_stall_s  = 1'b1;
          exmem_stall_s = 1'b1;
          memwb_flush_s = 1'b1;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_HALTED;
        end else begin
          drain_inc_s = 1'b1;
        end
      end
      ST_HALTED: begin
        pc_stall_s    = 1'b1;
        ifid_stall_s  = 1'b1;
        idex_stall_s  = 1'b1;
        exmem_stall_s = 1'b1;
        memwb_flush_s = 1'b1;
        state_nxt_s   = ST_HALTED;
      end
      default: begin
        pc_stall_s    = 1'b1;
        ifid_stall_s  = 1'b1;
        idex_stall_s  = 1'b1;
        exmem_stall_s = 1'b1;
        memwb_flush_s = 1'b1;
        state_nxt_s   = ST_RUN;
      end
    endcase
  end

  // Drain counter: counts non-busy cycles spent in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_r <= {DW{1'b0}};
    end else if (drain_load_s) begin
      drain_cnt_r <= {DW{1'b0}};
    end else if (drain_inc_s) begin
      drain_cnt_r <= drain_cnt_r + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  // Data-memory watchdog; frozen once halted since inputs no longer matter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r  <= {WW{1'b0}};
      mem_err_r <= 1'b0;
    end else if (state_r == ST_HALTED) begin
      wd_cnt_r  <= wd_cnt_r;
      mem_err_r <= mem_err_r;
    end else if (dmem_busy) begin
      if (wd_cnt_r == WD_MAX) begin
        wd_cnt_r  <= wd_cnt_r;
        mem_err_r <= 1'b1;
      end else begin
        wd_cnt_r  <= wd_cnt_r + {{(WW-1){1'b0}}, 1'b1};
        mem_err_r <= mem_err_r;
      end
    end else begin
      wd_cnt_r  <= {WW{1'b0}};
      mem_err_r <= mem_err_r;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating performance counters, idle while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != ST_HALTED) && pc_stall_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((state_r != ST_HALTED) && (ifid_flush_s || idex_flush_s) && !(&flush_cnt_r)) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_cycles = flush_cnt_r;
`endif

  assign pc_stall    = pc_stall_s;
  assign IFID_stall  = ifid_stall_s;
  assign IDEX_stall  = idex_stall_s;
  assign EXMEM_stall = exmem_stall_s;
  assign IFID_flush  = ifid_flush_s;
  assign IDEX_flush  = idex_flush_s;
  assign MEMWB_flush = memwb_flush_s;
  assign halted      = (state_r == ST_HALTED);
  assign mem_err     = mem_err_r;

endmodule
